btn_debounce_multi: RTL and testbench

- Parametrised, multi-channel successor of the single-button debounce/one-pulse block.
- Per channel:
  - 2-FF input synchroniser.
  - Counter-based debounce with a configurable stable period.
  - Registered debounced level.
  - One-cycle press and release pulses.
  - One-cycle long-press pulse.
- Sits between the board push-buttons and the braille input/control FSMs. Replaces per-button instances with a single bus-wide block.

---
 rtl/btn_db_pkg.sv | 20 ++
 rtl/btn_db_chan.sv | 137 +++++++++++++
 rtl/btn_debounce_multi.sv | 36 +++
 tb/tb_btn_debounce_multi.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_db_pkg.sv
// Shared types and sizing helpers for the multi-channel button debouncer.
package btn_db_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } btn_state_e;

    localparam int N_BTN_DEF         = 5;
    localparam int DB_CYCLES_DEF     = 8;
    localparam int LONG_CYCLES_DEF   = 1000;
    localparam int REPEAT_CYCLES_DEF = 200;

    // Bits needed for a counter that must be able to hold maxCount.
    function automatic int cntWidth(input int maxCount);
        return $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/btn_db_chan.sv
// One button channel: 2-FF synchroniser, counter debounce, hold FSM and pulses.
// Auto-repeat in the LONG state is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_db_chan
    import btn_db_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DbW   = cntWidth(DB_CYCLES);
    localparam int HoldW = cntWidth(LONG_CYCLES);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [DbW-1:0]   dbCnt_q, dbCnt_d;
    logic             level_q, level_d;
    btn_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             riseEv, fallEv;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RepW = cntWidth(REPEAT_CYCLES);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
    logic [RepW-1:0] rep_q, rep_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            dbCnt_q   <= '0;
            level_q   <= 1'b0;
            state_q   <= IDLE;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            s1_q      <= btn_i;
            s2_q      <= s1_q;
            dbCnt_q   <= dbCnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`endif

    // Any cycle where the synchronised input agrees with the level restarts the count.
    always_comb begin
        dbCnt_d = dbCnt_q;
        level_d = level_q;
        riseEv  = 1'b0;
        fallEv  = 1'b0;
        if (s2_q == level_q) begin
            dbCnt_d = '0;
        end else if (dbCnt_q == DbLast) begin
            dbCnt_d = '0;
            level_d = s2_q;
            riseEv  = s2_q;
            fallEv  = ~s2_q;
        end else begin
            dbCnt_d = dbCnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = riseEv;
        release_d = fallEv;
        long_d    = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        rep_d     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (riseEv) begin
                    state_d = HELD;
                    hold_d  = '0;
                end
            end
            HELD: begin
                if (fallEv) begin
                    state_d = IDLE;
                end else if (hold_q == HoldLast) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                    hold_d  = hold_q + 1'b1;
                end else begin
                    hold_d  = hold_q + 1'b1;
                end
            end
            LONG: begin
                if (fallEv) begin
                    state_d = IDLE;
`ifdef BTN_AUTO_REPEAT_EN
                end else if (rep_q == RepLast) begin
                    press_d = 1'b1;
                    rep_d   = '0;
                end else begin
                    rep_d   = rep_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// Bus-wide debouncer: N_BTN independent btn_db_chan instances.
// Define BTN_AUTO_REPEAT_EN to enable o_press auto-repeat after a long press.
module btn_debounce_multi
    import btn_db_pkg::*;
#(
    parameter int N_BTN         = N_BTN_DEF,
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long
);

    for (genvar g = 0; g < N_BTN; g++) begin : gChan
        btn_db_chan #(
            .DB_CYCLES    (DB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .btn_i    (i_btn[g]),
            .level_o  (o_level[g]),
            .press_o  (o_press[g]),
            .release_o(o_release[g]),
            .long_o   (o_long[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed plus random stimulus for btn_debounce_multi, checked every cycle against
// an elapsed-time reference model; honours BTN_AUTO_REPEAT_EN like the design.
module tb_btn_debounce_multi;

    localparam int NB   = 2;
    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    logic          clk;
    logic          reset;
    logic [NB-1:0] i_btn;
    logic [NB-1:0] o_level, o_press, o_release, o_long;

    int checkCount = 0;
    int passCount  = 0;
    int cycleNum   = 0;

    int syncA[NB], syncB[NB], runLen[NB], mLevel[NB];
    int sincePress[NB], sinceLong[NB];
    logic [NB-1:0] expLevel, expPress, expRelease, expLong;
    int pressSeen[NB], releaseSeen[NB], longSeen[NB];

    btn_debounce_multi #(
        .N_BTN        (NB),
        .DB_CYCLES    (DB),
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_btn    (i_btn),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_long   (o_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycleNum, observed, expected);
    endtask

    // Model state after the upcoming posedge, expressed as run lengths and elapsed times.
    task automatic modelStep(input logic [NB-1:0] btn, input logic rst);
        for (int ch = 0; ch < NB; ch++) begin
            bit rise, fall, p, l;
            if (rst) begin
                syncA[ch] = 0; syncB[ch] = 0; runLen[ch] = 0; mLevel[ch] = 0;
                sincePress[ch] = -1; sinceLong[ch] = -1;
                expLevel[ch] = 0; expPress[ch] = 0; expRelease[ch] = 0; expLong[ch] = 0;
                continue;
            end
            rise = 0; fall = 0; l = 0;
            if (syncB[ch] != mLevel[ch]) begin
                runLen[ch]++;
                if (runLen[ch] == DB) begin
                    mLevel[ch] = syncB[ch];
                    runLen[ch] = 0;
                    rise = (mLevel[ch] == 1);
                    fall = (mLevel[ch] == 0);
                end
            end else begin
                runLen[ch] = 0;
            end
            syncB[ch] = syncA[ch];
            syncA[ch] = int'(btn[ch]);
            p = rise;
            if (fall) begin
                sincePress[ch] = -1; sinceLong[ch] = -1;
            end else if (rise) begin
                sincePress[ch] = 0; sinceLong[ch] = -1;
            end else if (sinceLong[ch] >= 0) begin
                sinceLong[ch]++;
`ifdef BTN_AUTO_REPEAT_EN
                if (sinceLong[ch] % REP == 0) p = 1;
`endif
            end else if (sincePress[ch] >= 0) begin
                sincePress[ch]++;
                if (sincePress[ch] == LONG) begin
                    l = 1;
                    sinceLong[ch] = 0;
                end
            end
            expLevel[ch]   = (mLevel[ch] == 1);
            expPress[ch]   = p;
            expRelease[ch] = fall;
            expLong[ch]    = l;
        end
    endtask

    task automatic compareNow();
        checkOutput("level",   32'(o_level),   32'(expLevel));
        checkOutput("press",   32'(o_press),   32'(expPress));
        checkOutput("release", 32'(o_release), 32'(expRelease));
        checkOutput("long",    32'(o_long),    32'(expLong));
        for (int ch = 0; ch < NB; ch++) begin
            pressSeen[ch]   += int'(o_press[ch] === 1'b1);
            releaseSeen[ch] += int'(o_release[ch] === 1'b1);
            longSeen[ch]    += int'(o_long[ch] === 1'b1);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] btn, input logic rst);
        @(negedge clk);
        compareNow();
        i_btn = btn;
        reset = rst;
        modelStep(btn, rst);
        cycleNum++;
    endtask

    task automatic clearCounts();
        for (int ch = 0; ch < NB; ch++) begin
            pressSeen[ch] = 0; releaseSeen[ch] = 0; longSeen[ch] = 0;
        end
    endtask

    initial begin
        logic [NB-1:0] rndBtn;
        reset = 1'b1;
        i_btn = 2'b11;
        modelStep(2'b11, 1'b1);
        clearCounts();

        // Reset held with both buttons pressed, then both rise after the debounce latency.
        repeat (3)  applyStimulus(2'b11, 1'b1);
        repeat (10) applyStimulus(2'b11, 1'b0);
        checkOutput("rstPress0", pressSeen[0], 1);
        checkOutput("rstPress1", pressSeen[1], 1);
        repeat (12) applyStimulus(2'b00, 1'b0);

        // ch0 bounces with 2-cycle runs, then settles high.
        clearCounts();
        for (int i = 0; i < 20; i++) applyStimulus({1'b0, ((i / 2) % 2 == 0)}, 1'b0);
        repeat (12) applyStimulus(2'b01, 1'b0);
        checkOutput("bouncePress0", pressSeen[0], 1);
        checkOutput("bouncePress1", pressSeen[1], 0);
        checkOutput("bounceRelease0", releaseSeen[0], 0);
        repeat (12) applyStimulus(2'b00, 1'b0);

        // Short press: no long pulse.
        clearCounts();
        repeat (14) applyStimulus(2'b01, 1'b0);
        repeat (12) applyStimulus(2'b00, 1'b0);
        checkOutput("shortPress0", pressSeen[0], 1);
        checkOutput("shortLong0", longSeen[0], 0);
        checkOutput("shortRelease0", releaseSeen[0], 1);

        // ch1 long hold.
        clearCounts();
        repeat (40) applyStimulus(2'b10, 1'b0);
        repeat (12) applyStimulus(2'b00, 1'b0);
        checkOutput("holdLong1", longSeen[1], 1);
`ifdef BTN_AUTO_REPEAT_EN
        checkOutput("holdPress1", pressSeen[1], 3);
`else
        checkOutput("holdPress1", pressSeen[1], 1);
`endif
        checkOutput("holdRelease1", releaseSeen[1], 1);
        checkOutput("holdSilent0", pressSeen[0], 0);

        // Glitches of 1 and DB-1 cycles.
        clearCounts();
        applyStimulus(2'b01, 1'b0);
        repeat (8) applyStimulus(2'b00, 1'b0);
        repeat (3) applyStimulus(2'b01, 1'b0);
        repeat (8) applyStimulus(2'b00, 1'b0);
        checkOutput("glitchPress0", pressSeen[0], 0);
        checkOutput("glitchRelease0", releaseSeen[0], 0);

        // Reset while ch0 is in LONG, button kept pressed.
        clearCounts();
        repeat (30) applyStimulus(2'b01, 1'b0);
        checkOutput("preRstLong0", longSeen[0], 1);
        clearCounts();
        applyStimulus(2'b01, 1'b1);
        repeat (40) applyStimulus(2'b01, 1'b0);
        checkOutput("postRstLong0", longSeen[0], 1);
        repeat (12) applyStimulus(2'b00, 1'b0);

        // Random slow toggling with occasional resets.
        rndBtn = '0;
        for (int i = 0; i < 800; i++) begin
            for (int ch = 0; ch < NB; ch++)
                if ($urandom_range(0, 9) == 0) rndBtn[ch] = ~rndBtn[ch];
            applyStimulus(rndBtn, ($urandom_range(0, 299) == 0));
        end

        @(negedge clk);
        compareNow();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
